iq_sample_pacer: RTL and testbench
==================================

Name: iq_sample_pacer

Overview:
- Reads interleaved I/Q bytes from the IQ FIFO that the SPI packet controller fills, and presents one signed I/Q pair to the modulator at a programmable sample rate.
- Acts as the read-side scheduler of the FIFO: it primes to a start threshold, prefetches whole pairs, paces output with a tick divider, and counts underruns.
- Sits between the IQ FIFO read port and the transmit datapath.

Parameters:
- MIN_DIV, 4, minimum effective tick divisor. It guarantees a two-byte fetch completes between ticks.
- LVL_W, 12, width of the FIFO level and threshold buses.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run request from the configuration logic
- rate_div  in  16  tick period minus 1, in clk cycles
- start_thresh  in  LVL_W  FIFO byte level required before the first sample
- fifo_level  in  LVL_W  bytes currently held in the FIFO
- fifo_data_out  in  8  FIFO read data, valid the cycle after fifo_rd
- fifo_rd  out  1  FIFO read strobe, one byte per cycle asserted
- i_out  out  8  current I sample (signed)
- q_out  out  8  current Q sample (signed)
- iq_valid  out  1  one-cycle pulse when i_out/q_out update
- running  out  1  high in S_RUN / S_FETCH_I / S_FETCH_Q / S_LAT_Q
- underrun  out  1  sticky flag: a tick found no staged pair
- underrun_clr  in  1  clears underrun and underrun_cnt
- underrun_cnt  out  8  saturating count of underrun ticks

Behaviour:
- Reset (rst=1 at a clk edge): state=S_IDLE. All outputs are 0, including fifo_rd, i_out, q_out, iq_valid, running, underrun and underrun_cnt. Tick counter=0, staged pair empty. Reset asserted mid-fetch abandons the fetch; no further fifo_rd is issued.
- Effective divisor: div_eff = max(rate_div, MIN_DIV-1). The tick period is div_eff+1 cycles. The counter runs only while running=1. A tick occurs when count==div_eff, and the counter wraps to 0 on that cycle.
- FSM states:
  - S_IDLE: outputs hold their last values. If enable=1, go to S_PRIME.
  - S_PRIME: wait until fifo_level >= start_thresh and fifo_level >= 2, then go to S_FETCH_I. The counter is cleared on entry. If enable=0, go to S_IDLE.
  - S_FETCH_I: fifo_rd=1 for one cycle, then go to S_FETCH_Q.
  - S_FETCH_Q: fifo_rd=1. fifo_data_out is latched into stage_i. Go to S_LAT_Q.
  - S_LAT_Q: fifo_data_out is latched into stage_q, staged=1. Go to S_RUN.
  - S_RUN: if staged=0, fifo_level>=2 and enable=1, go to S_FETCH_I. If enable=0 and no fetch is in flight, go to S_IDLE.
- Pairs are never split. A fetch always takes exactly two bytes, and only starts when fifo_level>=2. A deasserted enable takes effect only after S_LAT_Q completes.
- On a tick with staged=1: i_out<=stage_i, q_out<=stage_q, iq_valid=1 for one cycle, staged<=0.
- On a tick with staged=0:
  - i_out<=0, q_out<=0, iq_valid=1.
  - underrun<=1 and underrun_cnt increments, saturating at 255.
- If a tick lands in the same cycle as S_LAT_Q, the newly latched pair is not output. It waits for the next tick, and the tick counts as an underrun only if staged was 0 before that cycle.
- Ticks keep occurring in every running state (S_FETCH_I, S_FETCH_Q, S_LAT_Q, S_RUN).
- If underrun_clr and an underrun happen in the same cycle, the clear wins and the final values are underrun=0, underrun_cnt=0.
- rate_div and start_thresh are sampled every cycle. A change applies from the next counter comparison. If the counter is already above a new div_eff, it runs to 0xFFFF and wraps.
- After the first pair, latency from a tick to the next staged pair is 4 cycles when bytes are available. This is why MIN_DIV=4.

Test Plan:
- Prime and pace: rate_div=9, start_thresh=6, load bytes 01,02,03,04,05,06, enable=1.
  - Expect 3 iq_valid pulses exactly 10 cycles apart, carrying (01,02), (03,04), (05,06).
  - fifo_rd asserted exactly 6 cycles total.
- Underrun: continue the previous test with no new bytes.
  - Expect the 4th tick to give i_out=q_out=0, underrun=1, underrun_cnt=1.
  - After 3 more ticks, underrun_cnt=4. Pulsing underrun_clr gives 0/0.
- Divisor clamp: rate_div=0 with ample data.
  - Expect iq_valid every 4 cycles and no underrun.
- Odd level: fifo_level=1 in S_RUN.
  - Expect no fifo_rd. When level reaches 2, the fetch completes and the pair appears on the next tick.
- Enable drop mid-fetch: deassert enable during S_FETCH_I.
  - Expect both bytes read, then state S_IDLE, running=0, outputs holding.
- Reset mid-fetch: rst in S_FETCH_Q.
  - Expect next cycle fifo_rd=0, all outputs 0, state S_IDLE.
- Saturation: 300 underrun ticks.
  - Expect underrun_cnt=255.

Source files
------------

// File: rtl/iq_sample_pacer_if.sv
// ---------------------------------------------------------------------------
// iq_sample_pacer_if
// Read-side port of the IQ FIFO as seen by the sample pacer.
//   fifo_rd        : read strobe, one byte per asserted cycle (pacer -> FIFO)
//   fifo_data_out  : read data, valid the cycle after fifo_rd (FIFO -> pacer)
//   fifo_level     : number of bytes currently held (FIFO -> pacer)
// The master modport is the pacer (the reader); the slave modport is the FIFO.
// ---------------------------------------------------------------------------
interface iq_sample_pacer_if #(
  parameter int LVL_W = 12
);

  logic             fifo_rd;
  logic [7:0]       fifo_data_out;
  logic [LVL_W-1:0] fifo_level;

  modport master (
    output fifo_rd,
    input  fifo_data_out,
    input  fifo_level
  );

  modport slave (
    input  fifo_rd,
    output fifo_data_out,
    output fifo_level
  );

endinterface

// File: rtl/iq_sample_pacer.sv
// ---------------------------------------------------------------------------
// iq_sample_pacer
// Read-side scheduler of the IQ FIFO. Waits for the FIFO to reach a start
// threshold, prefetches whole I/Q byte pairs into a one-pair stage, and
// presents one signed I/Q pair to the modulator on every tick of a
// programmable divider. A tick that finds no staged pair emits zeros and is
// counted as an underrun.
//
// Ports:
//   clk, rst       : system clock, synchronous active-high reset
//   enable         : run request from the configuration logic
//   rate_div       : tick period minus 1 in clk cycles (clamped to MIN_DIV-1)
//   start_thresh   : FIFO byte level required before the first fetch
//   fifo           : FIFO read port (master modport of iq_sample_pacer_if)
//   i_out, q_out   : current signed I and Q samples
//   iq_valid       : one-cycle pulse on every tick
//   running        : high while fetching or pacing
//   underrun       : sticky flag, a tick found no staged pair
//   underrun_clr   : clears underrun and underrun_cnt (wins over a new underrun)
//   underrun_cnt   : saturating count of underrun ticks
// ---------------------------------------------------------------------------
module iq_sample_pacer #(
  parameter int MIN_DIV = 4,
  parameter int LVL_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [15:0]       rate_div,
  input  logic [LVL_W-1:0]  start_thresh,
  iq_sample_pacer_if.master fifo,
  output logic [7:0]        i_out,
  output logic [7:0]        q_out,
  output logic              iq_valid,
  output logic              running,
  output logic              underrun,
  input  logic              underrun_clr,
  output logic [7:0]        underrun_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_FETCH_I,
    S_FETCH_Q,
    S_LAT_Q,
    S_RUN
  } state_t;

  localparam logic [15:0] DIV_FLOOR = 16'(MIN_DIV - 1);

  state_t      state_q;
  logic [15:0] count_q;
  logic [15:0] count_d;
  logic [7:0]  stageI_q;
  logic [7:0]  stageQ_q;
  logic        staged_q;
  logic        fifoRd_q;
  logic [7:0]  iOut_q;
  logic [7:0]  qOut_q;
  logic        iqValid_q;
  logic        running_q;
  logic        underrun_q;
  logic [7:0]  underrunCnt_q;

  logic [15:0] divEff;
  logic        tickHit;
  logic        pairAvail;
  logic        primeOk;
  logic        stagedAfter;

  // Divider and fetch-decision helpers. The divisor is clamped so that a
  // complete two-byte fetch always fits between two ticks. stagedAfter is
  // the value the stage will hold after this cycle: looking through a tick
  // that consumes the pair lets the refetch start immediately, which keeps
  // the tick-to-restaged latency at four cycles.
  always_comb begin
    divEff      = (rate_div < DIV_FLOOR) ? DIV_FLOOR : rate_div;
    tickHit     = running_q && (count_q == divEff);
    count_d     = tickHit ? 16'd0 : count_q + 16'd1;
    pairAvail   = (fifo.fifo_level >= LVL_W'(2));
    primeOk     = pairAvail && (fifo.fifo_level >= start_thresh);
    stagedAfter = staged_q && !tickHit;
  end

  // Single state machine with all outputs registered. The tick handling
  // comes first and the state case after it, so that a pair latched in
  // S_LAT_Q on a tick cycle stays staged for the following tick instead of
  // being dropped. The underrun clear is placed after the tick handling so
  // it wins over a simultaneous underrun. Reset abandons any fetch in flight
  // and drops the read strobe on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      count_q       <= 16'd0;
      stageI_q      <= 8'd0;
      stageQ_q      <= 8'd0;
      staged_q      <= 1'b0;
      fifoRd_q      <= 1'b0;
      iOut_q        <= 8'd0;
      qOut_q        <= 8'd0;
      iqValid_q     <= 1'b0;
      running_q     <= 1'b0;
      underrun_q    <= 1'b0;
      underrunCnt_q <= 8'd0;
    end else begin
      fifoRd_q  <= 1'b0;
      iqValid_q <= 1'b0;

      if (running_q) begin
        count_q <= count_d;
      end

      if (tickHit) begin
        iqValid_q <= 1'b1;
        if (staged_q) begin
          iOut_q   <= stageI_q;
          qOut_q   <= stageQ_q;
          staged_q <= 1'b0;
        end else begin
          iOut_q     <= 8'd0;
          qOut_q     <= 8'd0;
          underrun_q <= 1'b1;
          if (underrunCnt_q != 8'hFF) begin
            underrunCnt_q <= underrunCnt_q + 8'd1;
          end
        end
      end

      if (underrun_clr) begin
        underrun_q    <= 1'b0;
        underrunCnt_q <= 8'd0;
      end

      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_PRIME;
            count_q <= 16'd0;
          end
        end
        S_PRIME: begin
          if (!enable) begin
            state_q <= S_IDLE;
          end else if (primeOk) begin
            state_q   <= S_FETCH_I;
            fifoRd_q  <= 1'b1;
            running_q <= 1'b1;
          end
        end
        S_FETCH_I: begin
          state_q  <= S_FETCH_Q;
          fifoRd_q <= 1'b1;
        end
        S_FETCH_Q: begin
          stageI_q <= fifo.fifo_data_out;
          state_q  <= S_LAT_Q;
        end
        S_LAT_Q: begin
          stageQ_q <= fifo.fifo_data_out;
          staged_q <= 1'b1;
          state_q  <= S_RUN;
        end
        S_RUN: begin
          if (!enable) begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
          end else if (!stagedAfter && pairAvail) begin
            state_q  <= S_FETCH_I;
            fifoRd_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign fifo.fifo_rd = fifoRd_q;
  assign i_out        = iOut_q;
  assign q_out        = qOut_q;
  assign iq_valid     = iqValid_q;
  assign running      = running_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrunCnt_q;

endmodule

// File: tb/tb_iq_sample_pacer.sv
// ---------------------------------------------------------------------------
// tb_iq_sample_pacer
// Directed bench for iq_sample_pacer. A byte-array FIFO model feeds the read
// port; every pair loaded into the FIFO is also pushed to an expected-pair
// queue, and each iq_valid pulse pops the queue (empty queue means an
// underrun tick, so zeros are expected).
// ---------------------------------------------------------------------------
module tb_iq_sample_pacer;

  localparam int LVL_W = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable;
  logic             underrun_clr;
  logic [15:0]      rate_div;
  logic [LVL_W-1:0] start_thresh;
  logic [7:0]       i_out;
  logic [7:0]       q_out;
  logic [7:0]       underrun_cnt;
  logic             iq_valid;
  logic             running;
  logic             underrun;

  iq_sample_pacer_if #(.LVL_W(LVL_W)) fifoIf ();

  iq_sample_pacer #(.MIN_DIV(4), .LVL_W(LVL_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .rate_div     (rate_div),
    .start_thresh (start_thresh),
    .fifo         (fifoIf),
    .i_out        (i_out),
    .q_out        (q_out),
    .iq_valid     (iq_valid),
    .running      (running),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .underrun_cnt (underrun_cnt)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  logic [7:0] fifoMem [0:1023];
  int         wrPtr = 0;
  int         rdPtr = 0;
  int         cyc = 0;
  int         rdCount = 0;
  int         checks = 0;
  int         errors = 0;
  int         validCyc = 0;
  logic [15:0] expQ [$];

  // FIFO model: the write pointer is owned by the stimulus, the read pointer
  // by this block. Read data appears the cycle after the strobe, and the
  // FIFO is flushed while the system reset is held.
  assign fifoIf.fifo_level = LVL_W'(wrPtr - rdPtr);

  always @(posedge clk) begin
    if (rst) begin
      rdPtr <= wrPtr;
    end else if (fifoIf.fifo_rd) begin
      fifoIf.fifo_data_out <= fifoMem[rdPtr[9:0]];
      rdPtr <= rdPtr + 1;
    end
  end

  // Cycle counter and a running tally of FIFO read strobes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifoIf.fifo_rd) begin
      rdCount <= rdCount + 1;
    end
  end

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    fifoMem[wrPtr[9:0]] = b;
    wrPtr = wrPtr + 1;
  endtask

  task automatic applyStimulus(input logic [7:0] iVal, input logic [7:0] qVal);
    pushByte(iVal);
    pushByte(qVal);
    expQ.push_back({iVal, qVal});
  endtask

  task automatic waitValid(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (iq_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_seen"}, 32'(iq_valid), 32'd1);
    validCyc = cyc;
  endtask

  task automatic checkPair(input string tag);
    logic [15:0] e;
    e = (expQ.size() > 0) ? expQ.pop_front() : 16'h0000;
    checkOutput(tag, 32'({i_out, q_out}), 32'(e));
  endtask

  task automatic doReset();
    rst          = 1'b1;
    enable       = 1'b0;
    underrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expQ.delete();
  endtask

  int lastCyc;
  int rdBase;

  initial begin
    rate_div     = 16'd9;
    start_thresh = LVL_W'(6);
    enable       = 1'b0;
    underrun_clr = 1'b0;
    doReset();

    $display("[TB] reset state");
    checkOutput("reset_fifo_rd", 32'(fifoIf.fifo_rd), 32'd0);
    checkOutput("reset_iq", 32'({i_out, q_out}), 32'd0);
    checkOutput("reset_iq_valid", 32'(iq_valid), 32'd0);
    checkOutput("reset_running", 32'(running), 32'd0);
    checkOutput("reset_underrun", 32'(underrun), 32'd0);
    checkOutput("reset_underrun_cnt", 32'(underrun_cnt), 32'd0);

    $display("[TB] prime and pace");
    rdBase = rdCount;
    applyStimulus(8'h01, 8'h02);
    applyStimulus(8'h03, 8'h04);
    applyStimulus(8'h05, 8'h06);
    enable = 1'b1;
    waitValid("t1_p1", 40);
    checkPair("t1_pair1");
    lastCyc = validCyc;
    waitValid("t1_p2", 20);
    checkPair("t1_pair2");
    checkOutput("t1_gap2", 32'(validCyc - lastCyc), 32'd10);
    lastCyc = validCyc;
    waitValid("t1_p3", 20);
    checkPair("t1_pair3");
    checkOutput("t1_gap3", 32'(validCyc - lastCyc), 32'd10);
    lastCyc = validCyc;
    checkOutput("t1_rd_total", 32'(rdCount - rdBase), 32'd6);

    $display("[TB] underrun");
    waitValid("t2_u1", 20);
    checkPair("t2_zero1");
    checkOutput("t2_gap", 32'(validCyc - lastCyc), 32'd10);
    checkOutput("t2_flag", 32'(underrun), 32'd1);
    checkOutput("t2_cnt1", 32'(underrun_cnt), 32'd1);
    repeat (3) begin
      waitValid("t2_un", 20);
      checkPair("t2_zero");
    end
    checkOutput("t2_cnt4", 32'(underrun_cnt), 32'd4);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    checkOutput("t2_clr_flag", 32'(underrun), 32'd0);
    checkOutput("t2_clr_cnt", 32'(underrun_cnt), 32'd0);

    $display("[TB] divisor clamp");
    doReset();
    rate_div     = 16'd0;
    start_thresh = LVL_W'(2);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    enable = 1'b1;
    waitValid("t3_first", 40);
    checkPair("t3_pair");
    lastCyc = validCyc;
    for (int k = 1; k < 8; k++) begin
      waitValid("t3_next", 8);
      checkPair("t3_pair");
      checkOutput("t3_gap", 32'(validCyc - lastCyc), 32'd4);
      lastCyc = validCyc;
    end
    checkOutput("t3_no_underrun", 32'(underrun), 32'd0);
    enable = 1'b0;

    $display("[TB] odd level");
    doReset();
    rate_div     = 16'd9;
    start_thresh = LVL_W'(2);
    applyStimulus(8'h7F, 8'h80);
    enable = 1'b1;
    waitValid("t4_first", 40);
    checkPair("t4_pair1");
    rdBase = rdCount;
    pushByte(8'h11);
    waitValid("t4_u1", 20);
    checkPair("t4_zero1");
    checkOutput("t4_no_rd1", 32'(rdCount - rdBase), 32'd0);
    waitValid("t4_u2", 20);
    checkPair("t4_zero2");
    checkOutput("t4_no_rd2", 32'(rdCount - rdBase), 32'd0);
    pushByte(8'h22);
    expQ.push_back(16'h1122);
    waitValid("t4_p2", 20);
    checkPair("t4_pair2");
    checkOutput("t4_rd_pair", 32'(rdCount - rdBase), 32'd2);

    $display("[TB] enable drop mid-fetch");
    doReset();
    rate_div     = 16'd9;
    start_thresh = LVL_W'(2);
    applyStimulus(8'h5A, 8'hA5);
    applyStimulus(8'h33, 8'h44);
    enable = 1'b1;
    waitValid("t5_first", 40);
    checkPair("t5_pair1");
    checkOutput("t5_in_fetch_i", 32'(fifoIf.fifo_rd), 32'd1);
    rdBase = rdCount;
    enable = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("t5_rd_both", 32'(rdCount - rdBase), 32'd2);
    checkOutput("t5_running", 32'(running), 32'd0);
    checkOutput("t5_fifo_rd", 32'(fifoIf.fifo_rd), 32'd0);
    checkOutput("t5_hold_iq", 32'({i_out, q_out}), 32'h5AA5);
    repeat (12) @(negedge clk);
    checkOutput("t5_still_idle", 32'(running), 32'd0);
    checkOutput("t5_still_hold", 32'({i_out, q_out}), 32'h5AA5);

    $display("[TB] reset mid-fetch");
    doReset();
    rate_div     = 16'd3;
    start_thresh = LVL_W'(2);
    applyStimulus(8'hC3, 8'h3C);
    applyStimulus(8'h96, 8'h69);
    enable = 1'b1;
    waitValid("t6_first", 40);
    checkPair("t6_pair1");
    checkOutput("t6_fetch_i_rd", 32'(fifoIf.fifo_rd), 32'd1);
    @(negedge clk);
    checkOutput("t6_fetch_q_rd", 32'(fifoIf.fifo_rd), 32'd1);
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    checkOutput("t6_rd_off", 32'(fifoIf.fifo_rd), 32'd0);
    checkOutput("t6_iq_zero", 32'({i_out, q_out}), 32'd0);
    checkOutput("t6_valid_zero", 32'(iq_valid), 32'd0);
    checkOutput("t6_running_zero", 32'(running), 32'd0);
    checkOutput("t6_cnt_zero", 32'(underrun_cnt), 32'd0);
    rst = 1'b0;
    expQ.delete();
    rdBase = rdCount;
    repeat (4) @(negedge clk);
    checkOutput("t6_no_more_rd", 32'(rdCount - rdBase), 32'd0);

    $display("[TB] saturation");
    doReset();
    rate_div     = 16'd0;
    start_thresh = LVL_W'(0);
    applyStimulus(8'h01, 8'h02);
    enable = 1'b1;
    waitValid("t7_first", 40);
    checkPair("t7_pair");
    for (int k = 0; k < 300; k++) begin
      waitValid("t7_under", 8);
    end
    checkOutput("t7_sat_cnt", 32'(underrun_cnt), 32'd255);
    checkOutput("t7_sat_flag", 32'(underrun), 32'd1);
    repeat (3) @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    checkOutput("t7_collide_tick", 32'(iq_valid), 32'd1);
    checkOutput("t7_collide_flag", 32'(underrun), 32'd0);
    checkOutput("t7_collide_cnt", 32'(underrun_cnt), 32'd0);
    enable = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
